// File: rtl/airi5c_wb_arbiter.sv
// Writeback arbiter for the register file write port: EX has fixed priority, LSU/MD share a
// round-robin slot, debug writes preempt everything. A pending-write scoreboard drives hazard_o.
module airi5c_wb_arbiter #(
    parameter int unsigned XPR_LEN        = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      ex_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wa_i,
    input  logic [XPR_LEN-1:0]        ex_wd_i,

    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_wa_i,
    input  logic [XPR_LEN-1:0]        lsu_wd_i,

    input  logic                      md_valid_i,
    output logic                      md_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] md_wa_i,
    input  logic [XPR_LEN-1:0]        md_wd_i,
    input  logic [XPR_LEN-1:0]        md_wd2_i,
    input  logic                      md_rd64_i,

    input  logic                      iss_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] iss_wa_i,
    input  logic                      iss_rd64_i,

    input  logic [REG_ADDR_WIDTH-1:0] chk_ra1_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_ra2_i,
    output logic                      hazard_o,

    input  logic                      dm_wen_i,

    output logic                      wen_o,
    output logic [REG_ADDR_WIDTH-1:0] wa_o,
    output logic [XPR_LEN-1:0]        wd_o,
    output logic [XPR_LEN-1:0]        wd2_o,
    output logic                      use_rd64_o
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

    // rr_lsu_q high: LSU wins the next LSU/MD contention.
    logic                      rr_lsu_q, rr_lsu_d;
    logic                      wen_q, wen_d;
    logic [REG_ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [XPR_LEN-1:0]        wd_q, wd_d;
    logic [XPR_LEN-1:0]        wd2_q, wd2_d;
    logic                      rd64_q, rd64_d;
    logic [NumRegs-1:0]        pending_q, pending_d;
    logic [NumRegs-1:0]        set_mask, clr_mask;
    logic                      ex_xfer, lsu_xfer, md_xfer;

    assign lsu_ready_o = ~dm_wen_i & ~ex_valid_i & (rr_lsu_q | ~md_valid_i);
    assign md_ready_o  = ~dm_wen_i & ~ex_valid_i & (~rr_lsu_q | ~lsu_valid_i);

    // An EX result coinciding with a debug write is dropped.
    assign ex_xfer  = ex_valid_i & ~dm_wen_i;
    assign lsu_xfer = lsu_valid_i & lsu_ready_o;
    assign md_xfer  = md_valid_i & md_ready_o;

    always_comb begin
        wen_d    = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        wd2_d    = wd2_q;
        rd64_d   = rd64_q;
        rr_lsu_d = rr_lsu_q;
        if (ex_xfer) begin
            wen_d  = (ex_wa_i != '0);
            wa_d   = ex_wa_i;
            wd_d   = ex_wd_i;
            wd2_d  = '0;
            rd64_d = 1'b0;
        end else if (lsu_xfer) begin
            wen_d    = (lsu_wa_i != '0);
            wa_d     = lsu_wa_i;
            wd_d     = lsu_wd_i;
            wd2_d    = '0;
            rd64_d   = 1'b0;
            rr_lsu_d = 1'b0;
        end else if (md_xfer) begin
            wen_d    = md_rd64_i | (md_wa_i != '0);
            wa_d     = md_wa_i;
            wd_d     = md_wd_i;
            wd2_d    = md_wd2_i;
            rd64_d   = md_rd64_i;
            rr_lsu_d = 1'b1;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid_i) begin
            if (iss_rd64_i) begin
                set_mask[{iss_wa_i[REG_ADDR_WIDTH-1:1], 1'b0}] = 1'b1;
                set_mask[{iss_wa_i[REG_ADDR_WIDTH-1:1], 1'b1}] = 1'b1;
            end else begin
                set_mask[iss_wa_i] = 1'b1;
            end
        end
        // Clear only once the register file write is actually happening.
        if (wen_q) begin
            if (rd64_q) begin
                clr_mask[{wa_q[REG_ADDR_WIDTH-1:1], 1'b0}] = 1'b1;
                clr_mask[{wa_q[REG_ADDR_WIDTH-1:1], 1'b1}] = 1'b1;
            end else begin
                clr_mask[wa_q] = 1'b1;
            end
        end
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_lsu_q  <= 1'b1;
            wen_q     <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            wd2_q     <= '0;
            rd64_q    <= 1'b0;
            pending_q <= '0;
        end else begin
            rr_lsu_q  <= rr_lsu_d;
            wen_q     <= wen_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            wd2_q     <= wd2_d;
            rd64_q    <= rd64_d;
            pending_q <= pending_d;
        end
    end

    assign hazard_o   = pending_q[chk_ra1_i] | pending_q[chk_ra2_i];
    assign wen_o      = wen_q;
    assign wa_o       = wa_q;
    assign wd_o       = wd_q;
    assign wd2_o      = wd2_q;
    assign use_rd64_o = rd64_q;

endmodule

// File: tb/tb_airi5c_wb_arbiter.sv
// Self-checking bench for airi5c_wb_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of winner selection, output register and pending set.
module tb_airi5c_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_wa_i;
    logic [31:0] ex_wd_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_wa_i;
    logic [31:0] lsu_wd_i;
    logic        md_valid_i;
    logic        md_ready_o;
    logic [4:0]  md_wa_i;
    logic [31:0] md_wd_i;
    logic [31:0] md_wd2_i;
    logic        md_rd64_i;
    logic        iss_valid_i;
    logic [4:0]  iss_wa_i;
    logic        iss_rd64_i;
    logic [4:0]  chk_ra1_i;
    logic [4:0]  chk_ra2_i;
    logic        hazard_o;
    logic        dm_wen_i;
    logic        wen_o;
    logic [4:0]  wa_o;
    logic [31:0] wd_o;
    logic [31:0] wd2_o;
    logic        use_rd64_o;

    int n_checks = 0;
    int n_fail   = 0;

    airi5c_wb_arbiter #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_wa_i(ex_wa_i), .ex_wd_i(ex_wd_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_wa_i(lsu_wa_i),
        .lsu_wd_i(lsu_wd_i),
        .md_valid_i(md_valid_i), .md_ready_o(md_ready_o), .md_wa_i(md_wa_i), .md_wd_i(md_wd_i),
        .md_wd2_i(md_wd2_i), .md_rd64_i(md_rd64_i),
        .iss_valid_i(iss_valid_i), .iss_wa_i(iss_wa_i), .iss_rd64_i(iss_rd64_i),
        .chk_ra1_i(chk_ra1_i), .chk_ra2_i(chk_ra2_i), .hazard_o(hazard_o),
        .dm_wen_i(dm_wen_i),
        .wen_o(wen_o), .wa_o(wa_o), .wd_o(wd_o), .wd2_o(wd2_o), .use_rd64_o(use_rd64_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model. Source ids: 0 none, 1 EX, 2 LSU, 3 MD.
    int          m_last_grant = 3;
    bit          m_pend [32];
    bit          m_wen;
    bit [4:0]    m_wa;
    bit [31:0]   m_wd;
    bit [31:0]   m_wd2;
    bit          m_rd64;

    function automatic int pick(bit ex, bit lsu, bit md, bit dm);
        if (dm) return 0;
        if (ex) return 1;
        if (lsu && md) return (m_last_grant == 2) ? 3 : 2;
        if (lsu) return 2;
        if (md) return 3;
        return 0;
    endfunction

    // A source is ready exactly when it would win if it were requesting.
    function automatic bit exp_lsu_ready();
        return pick(ex_valid_i, 1'b1, md_valid_i, dm_wen_i) == 2;
    endfunction

    function automatic bit exp_md_ready();
        return pick(ex_valid_i, lsu_valid_i, 1'b1, dm_wen_i) == 3;
    endfunction

    function automatic bit exp_hazard();
        return m_pend[chk_ra1_i] | m_pend[chk_ra2_i];
    endfunction

    task automatic model_reset();
        m_last_grant = 3;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wen = 0; m_wa = 0; m_wd = 0; m_wd2 = 0; m_rd64 = 0;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        int w;
        int base;
        bit np [32];
        bit       n_wen;
        bit [4:0] n_wa;
        bit [31:0] n_wd, n_wd2;
        bit       n_rd64;
        w = pick(ex_valid_i, lsu_valid_i, md_valid_i, dm_wen_i);
        np = m_pend;
        if (m_wen) begin
            if (m_rd64) begin
                base = int'(m_wa) - int'(m_wa) % 2;
                np[base] = 1'b0; np[base + 1] = 1'b0;
            end else np[m_wa] = 1'b0;
        end
        if (iss_valid_i) begin
            if (iss_rd64_i) begin
                base = int'(iss_wa_i) - int'(iss_wa_i) % 2;
                np[base] = 1'b1; np[base + 1] = 1'b1;
            end else np[iss_wa_i] = 1'b1;
        end
        np[0] = 1'b0;
        n_wen = 0; n_wa = m_wa; n_wd = m_wd; n_wd2 = m_wd2; n_rd64 = m_rd64;
        case (w)
            1: begin n_wen = ex_wa_i != 0; n_wa = ex_wa_i; n_wd = ex_wd_i; n_wd2 = 0; n_rd64 = 0; end
            2: begin n_wen = lsu_wa_i != 0; n_wa = lsu_wa_i; n_wd = lsu_wd_i; n_wd2 = 0; n_rd64 = 0; end
            3: begin
                n_wen = md_rd64_i || md_wa_i != 0; n_wa = md_wa_i; n_wd = md_wd_i;
                n_wd2 = md_wd2_i; n_rd64 = md_rd64_i;
            end
            default: ;
        endcase
        @(posedge clk_i);
        if (rst_i) model_reset();
        else begin
            m_pend = np;
            m_wen = n_wen; m_wa = n_wa; m_wd = n_wd; m_wd2 = n_wd2; m_rd64 = n_rd64;
            if (w == 2 || w == 3) m_last_grant = w;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst_i = 0; ex_valid_i = 0; ex_wa_i = 0; ex_wd_i = 0;
        lsu_valid_i = 0; lsu_wa_i = 0; lsu_wd_i = 0;
        md_valid_i = 0; md_wa_i = 0; md_wd_i = 0; md_wd2_i = 0; md_rd64_i = 0;
        iss_valid_i = 0; iss_wa_i = 0; iss_rd64_i = 0;
        chk_ra1_i = 0; chk_ra2_i = 0; dm_wen_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_ra1_i = 5'd9; chk_ra2_i = 5'd17;
        #1;
        n_checks++;
        if ({wen_o, use_rd64_o} !== 2'b00) begin
            $display("FAIL reset_wen: got wen=%b rd64=%b want 0 0", wen_o, use_rd64_o); n_fail++;
        end
        n_checks++;
        if (wa_o !== 5'd0 || wd_o !== 32'd0 || wd2_o !== 32'd0) begin
            $display("FAIL reset_data: got wa=%0d wd=%h wd2=%h want 0", wa_o, wd_o, wd2_o); n_fail++;
        end
        n_checks++;
        if (hazard_o !== 1'b0) begin
            $display("FAIL reset_hazard: got %b want 0", hazard_o); n_fail++;
        end
    endtask

    task automatic test_lsu_single();
        do_reset();
        lsu_valid_i = 1; lsu_wa_i = 5'd5; lsu_wd_i = 32'h1234;
        #1;
        n_checks++;
        if (lsu_ready_o !== 1'b1) begin
            $display("FAIL lsu_single_ready: got %b want 1", lsu_ready_o); n_fail++;
        end
        tick();
        lsu_valid_i = 0;
        n_checks++;
        if (wen_o !== 1'b1 || wa_o !== 5'd5 || wd_o !== 32'h1234 || use_rd64_o !== 1'b0) begin
            $display("FAIL lsu_single_write: got wen=%b wa=%0d wd=%h rd64=%b want 1 5 1234 0",
                     wen_o, wa_o, wd_o, use_rd64_o);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_wa [3];
        exp_wa[0] = 5'd2; exp_wa[1] = 5'd3; exp_wa[2] = 5'd2;
        do_reset();
        ex_valid_i = 1; ex_wa_i = 5'd1; ex_wd_i = 32'hE0;
        lsu_valid_i = 1; lsu_wa_i = 5'd2; lsu_wd_i = 32'hA0;
        md_valid_i = 1; md_wa_i = 5'd3; md_wd_i = 32'hB0; md_wd2_i = 32'hB1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({lsu_ready_o, md_ready_o} !== 2'b00) begin
                $display("FAIL rr_ex_readies c%0d: got %b%b want 00", c, lsu_ready_o, md_ready_o);
                n_fail++;
            end
            tick();
            n_checks++;
            if (wen_o !== 1'b1 || wa_o !== 5'd1 || wd_o !== 32'hE0) begin
                $display("FAIL rr_ex_win c%0d: got wen=%b wa=%0d want 1 1", c, wen_o, wa_o);
                n_fail++;
            end
        end
        ex_valid_i = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({lsu_ready_o, md_ready_o} !== ((exp_wa[c] == 5'd2) ? 2'b10 : 2'b01)) begin
                $display("FAIL rr_readies c%0d: got %b%b", c, lsu_ready_o, md_ready_o); n_fail++;
            end
            tick();
            n_checks++;
            if (wen_o !== 1'b1 || wa_o !== exp_wa[c] || wd2_o !== ((c == 1) ? 32'hB1 : 32'h0)) begin
                $display("FAIL rr_grant c%0d: got wen=%b wa=%0d wd2=%h want 1 %0d", c, wen_o, wa_o,
                         wd2_o, exp_wa[c]);
                n_fail++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_hazard_clear();
        do_reset();
        iss_valid_i = 1; iss_wa_i = 5'd7;
        tick();
        iss_valid_i = 0; chk_ra1_i = 5'd7; chk_ra2_i = 5'd0;
        #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin
            $display("FAIL hazard_set: got %b want 1", hazard_o); n_fail++;
        end
        lsu_valid_i = 1; lsu_wa_i = 5'd7; lsu_wd_i = 32'h77;
        tick();
        lsu_valid_i = 0;
        #1;
        n_checks++;
        if (wen_o !== 1'b1 || wa_o !== 5'd7 || hazard_o !== 1'b1) begin
            $display("FAIL hazard_wb_cycle: got wen=%b wa=%0d hazard=%b want 1 7 1", wen_o, wa_o,
                     hazard_o);
            n_fail++;
        end
        tick();
        n_checks++;
        if (hazard_o !== 1'b0) begin
            $display("FAIL hazard_cleared: got %b want 0", hazard_o); n_fail++;
        end
    endtask

    task automatic test_rd64();
        do_reset();
        iss_valid_i = 1; iss_wa_i = 5'd10; iss_rd64_i = 1;
        tick();
        iss_valid_i = 0; iss_rd64_i = 0; chk_ra1_i = 5'd11; chk_ra2_i = 5'd0;
        #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin
            $display("FAIL rd64_pair_pending: got %b want 1", hazard_o); n_fail++;
        end
        md_valid_i = 1; md_wa_i = 5'd10; md_wd_i = 32'hA; md_wd2_i = 32'hB; md_rd64_i = 1;
        tick();
        md_valid_i = 0; md_rd64_i = 0;
        n_checks++;
        if (wen_o !== 1 || wa_o !== 5'd10 || wd_o !== 32'hA || wd2_o !== 32'hB || use_rd64_o !== 1)
        begin
            $display("FAIL rd64_write: got wen=%b wa=%0d wd=%h wd2=%h rd64=%b want 1 10 a b 1",
                     wen_o, wa_o, wd_o, wd2_o, use_rd64_o);
            n_fail++;
        end
        tick();
        chk_ra1_i = 5'd10; chk_ra2_i = 5'd11;
        #1;
        n_checks++;
        if (hazard_o !== 1'b0) begin
            $display("FAIL rd64_pair_cleared: got %b want 0", hazard_o); n_fail++;
        end
    endtask

    task automatic test_debug_yield();
        do_reset();
        dm_wen_i = 1; lsu_valid_i = 1; lsu_wa_i = 5'd12; lsu_wd_i = 32'hC0DE;
        #1;
        n_checks++;
        if ({lsu_ready_o, md_ready_o} !== 2'b00) begin
            $display("FAIL dm_readies: got %b%b want 00", lsu_ready_o, md_ready_o); n_fail++;
        end
        tick();
        n_checks++;
        if (wen_o !== 1'b0) begin
            $display("FAIL dm_wen: got %b want 0", wen_o); n_fail++;
        end
        dm_wen_i = 0;
        tick();
        lsu_valid_i = 0;
        n_checks++;
        if (wen_o !== 1'b1 || wa_o !== 5'd12 || wd_o !== 32'hC0DE) begin
            $display("FAIL dm_after: got wen=%b wa=%0d wd=%h want 1 12 c0de", wen_o, wa_o, wd_o);
            n_fail++;
        end
    endtask

    task automatic test_x0_and_set_wins();
        do_reset();
        lsu_valid_i = 1; lsu_wa_i = 5'd0; lsu_wd_i = 32'hDEAD;
        #1;
        n_checks++;
        if (lsu_ready_o !== 1'b1) begin
            $display("FAIL x0_ready: got %b want 1", lsu_ready_o); n_fail++;
        end
        tick();
        lsu_valid_i = 0;
        n_checks++;
        if (wen_o !== 1'b0) begin
            $display("FAIL x0_wen: got %b want 0", wen_o); n_fail++;
        end
        iss_valid_i = 1; iss_wa_i = 5'd3;
        tick();
        iss_valid_i = 0; lsu_valid_i = 1; lsu_wa_i = 5'd3; lsu_wd_i = 32'h33;
        tick();
        lsu_valid_i = 0; iss_valid_i = 1; iss_wa_i = 5'd3;
        tick();
        iss_valid_i = 0; chk_ra1_i = 5'd3; chk_ra2_i = 5'd0;
        #1;
        n_checks++;
        if (hazard_o !== 1'b1) begin
            $display("FAIL set_wins: got %b want 1", hazard_o); n_fail++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_i       = ($urandom_range(0, 79) == 0);
            dm_wen_i    = ($urandom_range(0, 9) == 0);
            ex_valid_i  = ($urandom_range(0, 3) == 0);
            ex_wa_i     = 5'($urandom); ex_wd_i = $urandom;
            lsu_valid_i = ($urandom_range(0, 9) < 6);
            lsu_wa_i    = 5'($urandom); lsu_wd_i = $urandom;
            md_valid_i  = ($urandom_range(0, 9) < 5);
            md_wa_i     = 5'($urandom); md_wd_i = $urandom; md_wd2_i = $urandom;
            md_rd64_i   = 1'($urandom);
            iss_valid_i = ($urandom_range(0, 2) == 0);
            iss_wa_i    = 5'($urandom); iss_rd64_i = ($urandom_range(0, 3) == 0);
            chk_ra1_i   = 5'($urandom); chk_ra2_i = 5'($urandom);
            #1;
            n_checks++;
            if (lsu_ready_o !== exp_lsu_ready() || md_ready_o !== exp_md_ready()) begin
                $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, lsu_ready_o, md_ready_o,
                         exp_lsu_ready(), exp_md_ready());
                n_fail++;
            end
            n_checks++;
            if (hazard_o !== exp_hazard()) begin
                $display("FAIL rand_hazard c%0d: got %b want %b", c, hazard_o, exp_hazard());
                n_fail++;
            end
            tick();
            n_checks++;
            if (wen_o !== m_wen || wa_o !== m_wa || wd_o !== m_wd || wd2_o !== m_wd2 ||
                use_rd64_o !== m_rd64) begin
                $display("FAIL rand_out c%0d: got %b %0d %h %h %b want %b %0d %h %h %b", c, wen_o,
                         wa_o, wd_o, wd2_o, use_rd64_o, m_wen, m_wa, m_wd, m_wd2, m_rd64);
                n_fail++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lsu_single();
        test_round_robin();
        test_hazard_clear();
        test_rd64();
        test_debug_yield();
        test_x0_and_set_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
